rk86_sram_arbiter: RTL and testbench

//   Sequences the single external async SRAM on the Karabas-Pro RK86 core. Replaces ad-hoc muxing with
//   two request/ack ports: video DMA (K580WT57 read channel) and CPU (K580WM80A, RAM space 0000-7FFF).

---
 rtl/rk86_pkg.sv | 14 +
 rtl/rk86_rr_starve_ctr.sv | 37 +++
 rtl/rk86_sram_arbiter.sv | 168 ++++++++++++++++
 tb/tb_rk86_sram_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rk86_pkg.sv
// Shared definitions for the RK86 SRAM arbiter: FSM state encoding and the default SRAM bank.
package rk86_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VID_RD = 3'd1,
        ST_CPU_RD = 3'd2,
        ST_CPU_WR = 3'd3,
        ST_TURN   = 3'd4
    } state_t;

    localparam logic [5:0] SRAM_BANK = 6'd0;

endpackage

// File: rtl/rk86_rr_starve_ctr.sv
// Counts video grants won while the CPU waits; raises force_cpu once the CPU has waited MAX_WAIT grants.
module rk86_rr_starve_ctr #(
    parameter int MAX_WAIT = 4
) (
    input  logic CLK_50MHZ,
    input  logic reset,
    input  logic vid_grant,
    input  logic cpu_grant,
    input  logic cpu_req,
    output logic force_cpu
);

    localparam int CNT_W = $clog2(MAX_WAIT + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (cpu_grant || !cpu_req) begin
            wait_cnt_d = '0;
        end else if (vid_grant && (wait_cnt_q != CNT_MAX)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK_50MHZ or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign force_cpu = cpu_req && (wait_cnt_q == CNT_MAX);

endmodule

// File: rtl/rk86_sram_arbiter.sv
// Two-port (video DMA / CPU) sequencer for the single async SRAM; all SRAM strobes are registered.
// Define RK86_SRAM_TURNAROUND_EN to insert a bus turnaround cycle after every CPU write.
module rk86_sram_arbiter
    import rk86_pkg::*;
#(
    parameter int         ACCESS_CYCLES = 3,
    parameter int         ADDR_W        = 15,
    parameter logic [5:0] BANK          = SRAM_BANK,
    parameter int         CPU_MAX_WAIT  = 4
) (
    input  logic              CLK_50MHZ,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [7:0]        vid_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    output logic [20:0]       SRAM_A,
    output logic              SRAM_NRD,
    output logic              SRAM_NWR,
    output logic [7:0]        sram_d_o,
    output logic              sram_d_oe,
    input  logic [7:0]        sram_d_i,
    output logic              busy
);

    localparam int PH_W = $clog2(ACCESS_CYCLES);
    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(ACCESS_CYCLES - 1);

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        vid_rdata_q, vid_rdata_d;
    logic [7:0]        cpu_rdata_q, cpu_rdata_d;
    logic              vid_ack_q, vid_ack_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              nrd_q, nrd_d;
    logic              nwr_q, nwr_d;
    logic              oe_q, oe_d;
    logic              busy_q, busy_d;
    logic              vid_grant, cpu_grant, force_cpu;

    rk86_rr_starve_ctr #(
        .MAX_WAIT (CPU_MAX_WAIT)
    ) u_starve (
        .CLK_50MHZ (CLK_50MHZ),
        .reset     (reset),
        .vid_grant (vid_grant),
        .cpu_grant (cpu_grant),
        .cpu_req   (cpu_req),
        .force_cpu (force_cpu)
    );

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        vid_rdata_d = vid_rdata_q;
        cpu_rdata_d = cpu_rdata_q;
        vid_ack_d   = 1'b0;
        cpu_ack_d   = 1'b0;
        vid_grant   = 1'b0;
        cpu_grant   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (vid_req && !force_cpu) begin
                    vid_grant = 1'b1;
                    addr_d    = vid_addr;
                    phase_d   = '0;
                    state_d   = ST_VID_RD;
                end else if (cpu_req) begin
                    cpu_grant = 1'b1;
                    addr_d    = cpu_addr;
                    wdata_d   = cpu_wdata;
                    phase_d   = '0;
                    state_d   = cpu_we ? ST_CPU_WR : ST_CPU_RD;
                end
            end
            ST_VID_RD, ST_CPU_RD, ST_CPU_WR: begin
                if (phase_q == LAST_PHASE) begin
                    phase_d = '0;
                    if (state_q == ST_VID_RD) begin
                        vid_rdata_d = sram_d_i;
                        vid_ack_d   = 1'b1;
                        state_d     = ST_IDLE;
                    end else if (state_q == ST_CPU_RD) begin
                        cpu_rdata_d = sram_d_i;
                        cpu_ack_d   = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        cpu_ack_d   = 1'b1;
`ifdef RK86_SRAM_TURNAROUND_EN
                        state_d     = ST_TURN;
`else
                        state_d     = ST_IDLE;
`endif
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
`ifdef RK86_SRAM_TURNAROUND_EN
            ST_TURN: begin
                state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes are derived from the next state so they change on the same edge as the FSM.
        nrd_d  = !((state_d == ST_VID_RD) || (state_d == ST_CPU_RD));
        oe_d   = (state_d == ST_CPU_WR);
        nwr_d  = !((state_d == ST_CPU_WR) && (phase_d != '0));
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK_50MHZ or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            vid_rdata_q <= '0;
            cpu_rdata_q <= '0;
            vid_ack_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            nrd_q       <= 1'b1;
            nwr_q       <= 1'b1;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            vid_rdata_q <= vid_rdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_ack_q   <= vid_ack_d;
            cpu_ack_q   <= cpu_ack_d;
            nrd_q       <= nrd_d;
            nwr_q       <= nwr_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
        end
    end

    assign vid_ack   = vid_ack_q;
    assign vid_rdata = vid_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign SRAM_A    = {BANK, 15'(addr_q)};
    assign SRAM_NRD  = nrd_q;
    assign SRAM_NWR  = nwr_q;
    assign sram_d_o  = wdata_q;
    assign sram_d_oe = oe_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rk86_sram_arbiter.sv
// Scenario bench for rk86_sram_arbiter with a behavioural async SRAM and per-port expected-data queues.
module tb_rk86_sram_arbiter;

    parameter int AC = 3;
    localparam int MAX_WAIT = 4;
    localparam int LAT = AC + 1;

    logic        CLK_50MHZ = 1'b0;
    logic        reset     = 1'b1;
    logic        vid_req   = 1'b0;
    logic [14:0] vid_addr  = '0;
    logic        vid_ack;
    logic [7:0]  vid_rdata;
    logic        cpu_req   = 1'b0;
    logic        cpu_we    = 1'b0;
    logic [14:0] cpu_addr  = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [20:0] SRAM_A;
    logic        SRAM_NRD;
    logic        SRAM_NWR;
    logic [7:0]  sram_d_o;
    logic        sram_d_oe;
    logic [7:0]  sram_d_i;
    logic        busy;

    logic [7:0]  mem [0:32767];
    logic        load_en   = 1'b0;
    logic [14:0] load_addr = '0;
    logic [7:0]  load_data = '0;

    int errors     = 0;
    int checks     = 0;
    int double_ack = 0;
    logic [7:0] vid_exp_q [$];
    logic [7:0] cpu_exp_q [$];

    rk86_sram_arbiter #(
        .ACCESS_CYCLES (AC),
        .ADDR_W        (15),
        .BANK          (6'd0),
        .CPU_MAX_WAIT  (MAX_WAIT)
    ) u_dut (
        .CLK_50MHZ (CLK_50MHZ),
        .reset     (reset),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_ack   (vid_ack),
        .vid_rdata (vid_rdata),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .SRAM_A    (SRAM_A),
        .SRAM_NRD  (SRAM_NRD),
        .SRAM_NWR  (SRAM_NWR),
        .sram_d_o  (sram_d_o),
        .sram_d_oe (sram_d_oe),
        .sram_d_i  (sram_d_i),
        .busy      (busy)
    );

    always #10 CLK_50MHZ = ~CLK_50MHZ;

    // Async SRAM model: drives data while NRD is low, captures writes at each clock while NWR is low.
    assign sram_d_i = SRAM_NRD ? 8'hFF : mem[SRAM_A[14:0]];

    always @(posedge CLK_50MHZ) begin
        if (load_en) mem[load_addr] <= load_data;
        else if (!SRAM_NWR && sram_d_oe) mem[SRAM_A[14:0]] <= sram_d_o;
    end

    task automatic preload(input logic [14:0] a, input logic [7:0] d);
        @(negedge CLK_50MHZ);
        load_addr = a;
        load_data = d;
        load_en   = 1'b1;
        @(negedge CLK_50MHZ);
        load_en   = 1'b0;
    endtask

    function automatic logic [7:0] pop_exp(input bit is_cpu);
        logic [7:0] v = 8'hXX;
        if (is_cpu) begin
            if (cpu_exp_q.size() > 0) v = cpu_exp_q.pop_front();
        end else if (vid_exp_q.size() > 0) begin
            v = vid_exp_q.pop_front();
        end
        return v;
    endfunction

    // Waits (bounded) for the selected ack, measuring strobe activity; drops that req in the ack cycle.
    task automatic wait_ack(input bit want_cpu, input int start, output int lat, output int nrd_low,
                            output int nwr_low, output logic [20:0] wr_addr, output logic [7:0] wr_data,
                            output logic [7:0] rdata);
        lat = -1; nrd_low = 0; nwr_low = 0; wr_addr = '0; wr_data = '0; rdata = 8'hXX;
        for (int c = start; c < start + 40 && lat < 0; c++) begin
            @(negedge CLK_50MHZ);
            if (!SRAM_NRD) nrd_low++;
            if (!SRAM_NWR) begin
                nwr_low++;
                wr_addr = SRAM_A;
                wr_data = sram_d_o;
            end
            if (vid_ack && cpu_ack) double_ack++;
            if (want_cpu ? cpu_ack : vid_ack) begin
                lat = c;
                rdata = want_cpu ? cpu_rdata : vid_rdata;
                if (want_cpu) cpu_req = 1'b0;
                else vid_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        preload(15'h76D0, 8'h41);
        preload(15'h1000, 8'h11);
        preload(15'h2000, 8'h22);
        @(negedge CLK_50MHZ);
        checks++; if (SRAM_NRD !== 1'b1) begin errors++; $display("[TB] FAIL reset_nrd: got %b want 1", SRAM_NRD); end
        checks++; if (SRAM_NWR !== 1'b1) begin errors++; $display("[TB] FAIL reset_nwr: got %b want 1", SRAM_NWR); end
        checks++; if (sram_d_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_oe: got %b want 0", sram_d_oe); end
        checks++; if (SRAM_A !== 21'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h want 000000", SRAM_A); end
        checks++; if ({vid_ack, cpu_ack} !== 2'b00) begin errors++; $display("[TB] FAIL reset_acks: got %b want 00", {vid_ack, cpu_ack}); end
        checks++; if ({vid_rdata, cpu_rdata} !== 16'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h want 0000", {vid_rdata, cpu_rdata}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_video_read();
        int lat, nrd_low, nwr_low;
        logic [20:0] wa;
        logic [7:0] wd, rd, exp;
        reset = 1'b0;
        @(negedge CLK_50MHZ);
        vid_addr = 15'h76D0;
        vid_req  = 1'b1;
        vid_exp_q.push_back(8'h41);
        wait_ack(1'b0, 1, lat, nrd_low, nwr_low, wa, wd, rd);
        exp = pop_exp(1'b0);
        checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL vid_latency: got %0d want %0d", lat, LAT); end
        checks++; if (nrd_low !== AC) begin errors++; $display("[TB] FAIL vid_nrd_width: got %0d want %0d", nrd_low, AC); end
        checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL vid_rdata: got %h want %h", rd, exp); end
        @(negedge CLK_50MHZ);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL vid_idle_after: got busy=%b want 0", busy); end
    endtask

    task automatic test_cpu_write_read();
        int lat, nrd_low, nwr_low;
        logic [20:0] wa;
        logic [7:0] wd, rd, exp;
        cpu_we    = 1'b1;
        cpu_addr  = 15'h0100;
        cpu_wdata = 8'hA5;
        cpu_req   = 1'b1;
        @(negedge CLK_50MHZ);
        // Address/data wiggle after grant must not reach the SRAM pins.
        cpu_addr  = 15'h7FFF;
        cpu_wdata = 8'h00;
        wait_ack(1'b1, 2, lat, nrd_low, nwr_low, wa, wd, rd);
        checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL wr_latency: got %0d want %0d", lat, LAT); end
        checks++; if (nwr_low !== AC - 1) begin errors++; $display("[TB] FAIL wr_nwr_width: got %0d want %0d", nwr_low, AC - 1); end
        checks++; if (nrd_low !== 0) begin errors++; $display("[TB] FAIL wr_nrd_width: got %0d want 0", nrd_low); end
        checks++; if (wa !== 21'h000100) begin errors++; $display("[TB] FAIL wr_addr: got %h want 000100", wa); end
        checks++; if (wd !== 8'hA5) begin errors++; $display("[TB] FAIL wr_data: got %h want a5", wd); end

        @(negedge CLK_50MHZ);
        cpu_we   = 1'b0;
        cpu_addr = 15'h0100;
        cpu_req  = 1'b1;
        cpu_exp_q.push_back(8'hA5);
        wait_ack(1'b1, 1, lat, nrd_low, nwr_low, wa, wd, rd);
        exp = pop_exp(1'b1);
        checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL rd_latency: got %0d want %0d", lat, LAT); end
        checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL rd_readback: got %h want %h", rd, exp); end
        @(negedge CLK_50MHZ);
    endtask

    task automatic test_starvation();
        bit order_q [$];
        int cnt = 0;
        int acks = 0;
        bit exp_cpu;
        logic [7:0] exp_d, got_d;
        for (int i = 0; i < 10; i++) begin
            if (cnt == MAX_WAIT) begin order_q.push_back(1'b1); cnt = 0; end
            else begin order_q.push_back(1'b0); cnt++; end
        end
        double_ack = 0;
        vid_addr = 15'h1000;
        cpu_addr = 15'h2000;
        cpu_we   = 1'b0;
        vid_req  = 1'b1;
        cpu_req  = 1'b1;
        for (int c = 0; c < 200 && acks < 10; c++) begin
            @(negedge CLK_50MHZ);
            if (vid_ack && cpu_ack) double_ack++;
            if (vid_ack || cpu_ack) begin
                exp_cpu = order_q.pop_front();
                exp_d   = exp_cpu ? 8'h22 : 8'h11;
                got_d   = cpu_ack ? cpu_rdata : vid_rdata;
                checks++; if (cpu_ack !== exp_cpu) begin errors++; $display("[TB] FAIL starve_order[%0d]: got cpu_ack=%b want %b", acks, cpu_ack, exp_cpu); end
                checks++; if (got_d !== exp_d) begin errors++; $display("[TB] FAIL starve_data[%0d]: got %h want %h", acks, got_d, exp_d); end
                acks++;
                if (acks == 10) begin
                    vid_req = 1'b0;
                    cpu_req = 1'b0;
                end
            end
        end
        vid_req = 1'b0;
        cpu_req = 1'b0;
        checks++; if (acks !== 10) begin errors++; $display("[TB] FAIL starve_ack_count: got %0d want 10", acks); end
        checks++; if (double_ack !== 0) begin errors++; $display("[TB] FAIL starve_double_ack: got %0d want 0", double_ack); end
        @(negedge CLK_50MHZ);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL starve_drain: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid_write();
        bit saw_ack = 1'b0;
        cpu_we    = 1'b1;
        cpu_addr  = 15'h0200;
        cpu_wdata = 8'h3C;
        cpu_req   = 1'b1;
        @(negedge CLK_50MHZ);
        @(negedge CLK_50MHZ);
        checks++; if (SRAM_NWR !== 1'b0) begin errors++; $display("[TB] FAIL abort_pre_nwr: got %b want 0", SRAM_NWR); end
        reset = 1'b1;
        #1;
        checks++; if (SRAM_NWR !== 1'b1) begin errors++; $display("[TB] FAIL abort_nwr: got %b want 1", SRAM_NWR); end
        checks++; if (sram_d_oe !== 1'b0) begin errors++; $display("[TB] FAIL abort_oe: got %b want 0", sram_d_oe); end
        cpu_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK_50MHZ);
            if (cpu_ack) saw_ack = 1'b1;
        end
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK_50MHZ);
            if (cpu_ack) saw_ack = 1'b1;
        end
        checks++; if (saw_ack !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_ack: got ack=%b want 0", saw_ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b want 0", busy); end
    endtask

    task automatic test_turnaround();
        int lat, nrd_low, nwr_low, gap;
        logic [20:0] wa;
        logic [7:0] wd, rd, exp;
`ifdef RK86_SRAM_TURNAROUND_EN
        int exp_gap = 2;
        logic exp_busy = 1'b1;
`else
        int exp_gap = 1;
        logic exp_busy = 1'b0;
`endif
        cpu_we    = 1'b1;
        cpu_addr  = 15'h0300;
        cpu_wdata = 8'h77;
        cpu_req   = 1'b1;
        @(negedge CLK_50MHZ);
        vid_addr = 15'h0300;
        vid_req  = 1'b1;
        vid_exp_q.push_back(8'h77);
        wait_ack(1'b1, 2, lat, nrd_low, nwr_low, wa, wd, rd);
        checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL turn_wr_latency: got %0d want %0d", lat, LAT); end
        checks++; if ({SRAM_NRD, SRAM_NWR, sram_d_oe} !== 3'b110) begin errors++; $display("[TB] FAIL turn_ack_pins: got %b want 110", {SRAM_NRD, SRAM_NWR, sram_d_oe}); end
        checks++; if (busy !== exp_busy) begin errors++; $display("[TB] FAIL turn_ack_busy: got %b want %b", busy, exp_busy); end
        gap = -1;
        for (int k = 1; k <= 10 && gap < 0; k++) begin
            @(negedge CLK_50MHZ);
            if (!SRAM_NRD) gap = k;
        end
        checks++; if (gap !== exp_gap) begin errors++; $display("[TB] FAIL turn_gap: got %0d want %0d", gap, exp_gap); end
        wait_ack(1'b0, 1, lat, nrd_low, nwr_low, wa, wd, rd);
        exp = pop_exp(1'b0);
        checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL turn_vid_rdata: got %h want %h", rd, exp); end
        @(negedge CLK_50MHZ);
    endtask

    initial begin
        test_reset();
        test_video_read();
        test_cpu_write_read();
        test_starvation();
        test_reset_mid_write();
        test_turnaround();
        checks++; if (double_ack !== 0) begin errors++; $display("[TB] FAIL double_ack_total: got %0d want 0", double_ack); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
